uart_rx: RTL and testbench

Byte-wide UART receiver; the receive-side counterpart of the controller's transmitter. Deserialises an 8N1 frame (start bit 0, eight data bits LSB first, stop bit 1) from `rxd`. It uses the same baud-tick enable `bclk` as the transmitter, running at OVERSAMPLE× the bit rate. It holds the received byte in a data register until the host acknowledges it with `rd`.

---
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling rxd on an oversampled baud enable.
// Holds each received byte with status flags until the host acknowledges it.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bclk,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic          rxd_m, rxd_s;
    logic [TW-1:0] tick_ctr, tick_nxt;
    logic [2:0]    bit_ctr, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          done;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_ctr <= '0;
            bit_ctr  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            tick_ctr <= tick_nxt;
            bit_ctr  <= bit_nxt;
            shreg    <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_ctr;
        bit_nxt   = bit_ctr;
        shreg_nxt = shreg;
        done      = 1'b0;
        if (bclk) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    if (tick_ctr == HALF_LAST) begin
                        tick_nxt = '0;
                        if (!rxd_s) begin
                            state_nxt = DATA;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_ctr + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_ctr == BIT_LAST) begin
                        shreg_nxt = {rxd_s, shreg[7:1]};
                        tick_nxt  = '0;
                        if (bit_ctr == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            bit_nxt = bit_ctr + 3'd1;
                        end
                    end else begin
                        tick_nxt = tick_ctr + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving half a bit early lets a back-to-back start edge be seen on time.
                    if (tick_ctr == BIT_LAST) begin
                        done      = 1'b1;
                        tick_nxt  = '0;
                        state_nxt = IDLE;
                    end else begin
                        tick_nxt = tick_ctr + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A completion outranks an acknowledge on the same clock; the old byte counts as read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout      <= '0;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (done) begin
            dout      <= shreg;
            frame_err <= ~rxd_s;
            rx_rdy    <= 1'b1;
            if (rd) begin
                overrun <= 1'b0;
            end else if (rx_rdy) begin
                overrun <= 1'b1;
            end
        end else if (rd) begin
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a serial frame generator acting as transmitter, with a
// byte/flag model of what the host should see after each frame.
module tb_uart_rx;

    localparam int OS        = 16;
    localparam int DONE_TICK = OS / 2 + 9 * OS + 1;  // edge 0 drives start, edge 1 detects it

    logic       clk, rst, bclk, rxd, rd;
    logic [7:0] dout;
    logic       rx_rdy, frame_err, overrun, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_dout;
    logic       exp_rdy, exp_fe, exp_ovr;
    logic       rdy_before, rdy_after;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .bclk(bclk), .rxd(rxd), .rd(rd),
        .dout(dout), .rx_rdy(rx_rdy), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock-wide baud enable every 4 clocks, changing away from clk rising edges.
    initial begin
        bclk = 1'b0;
        #30;
        forever begin
            bclk = 1'b1;
            #10;
            bclk = 1'b0;
            #30;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        while (bclk !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic model_reset();
        exp_dout = 8'h00;
        exp_rdy  = 1'b0;
        exp_fe   = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // Host-visible effect of a finished frame.
    task automatic model_done(input logic [7:0] data, input logic stop, input logic rd_now);
        if (rd_now) exp_ovr = 1'b0;
        else if (exp_rdy) exp_ovr = 1'b1;
        exp_rdy  = 1'b1;
        exp_fe   = ~stop;
        exp_dout = data;
    endtask

    // Transmit one frame; caller must be positioned just after a baud tick.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic rd_at_done);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int t = 0; t < 10 * OS; t++) begin
            rxd = bits[t / OS];
            if (t == DONE_TICK - 1 && rd_at_done) begin
                repeat (3) @(posedge clk);
                #1;
                rd = 1'b1;
            end
            tick();
            rd = 1'b0;
            if (t + 1 == DONE_TICK - 1) rdy_before = rx_rdy;
            if (t + 1 == DONE_TICK) begin
                rdy_after = rx_rdy;
                model_done(data, stop, rd_at_done);
            end
        end
        rxd = 1'b1;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        exp_rdy = 1'b0;
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] part;
        rst = 1'b0; rxd = 1'b1; rd = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++; if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rx_rdy: got %b want 0", rx_rdy); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick();
        send_frame(8'h96, 1'b1, 1'b0);
        n_cmp++; if (dout !== exp_dout) begin n_bad++; $display("FAIL pre_reset_dout: got %h want %h", dout, exp_dout); end
        // Partial frame: start bit plus four data bits, then reset.
        part = 8'hC3;
        rxd = 1'b0;
        wait_ticks(OS);
        for (int b = 0; b < 4; b++) begin
            rxd = part[b];
            wait_ticks(OS);
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midframe_busy: got %b want 1", busy); end
        rst = 1'b0;
        #2;
        model_reset();
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL async_reset_dout: got %h want 00", dout); end
        n_cmp++; if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL async_reset_rx_rdy: got %b want 0", rx_rdy); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        wait_ticks(20);
        n_cmp++; if ({dout, rx_rdy, frame_err, overrun, busy} !== 12'h000) begin
            n_bad++; $display("FAIL post_reset_state: got dout=%h rdy=%b fe=%b ovr=%b busy=%b want all 0", dout, rx_rdy, frame_err, overrun, busy);
        end
        send_frame(8'h3C, 1'b1, 1'b0);
        n_cmp++; if (dout !== 8'h3C) begin n_bad++; $display("FAIL after_reset_dout: got %h want 3c", dout); end
        n_cmp++; if (rx_rdy !== 1'b1) begin n_bad++; $display("FAIL after_reset_rx_rdy: got %b want 1", rx_rdy); end
    endtask

    task automatic test_nominal();
        pulse_rd();
        send_frame(8'hA5, 1'b1, 1'b0);
        n_cmp++; if (rdy_before !== 1'b0) begin n_bad++; $display("FAIL nominal_rdy_early: got %b want 0", rdy_before); end
        n_cmp++; if (rdy_after !== 1'b1) begin n_bad++; $display("FAIL nominal_rdy_on_time: got %b want 1", rdy_after); end
        n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL nominal_dout: got %h want a5", dout); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL nominal_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== exp_ovr) begin n_bad++; $display("FAIL nominal_overrun: got %b want %b", overrun, exp_ovr); end
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        exp_rdy = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0;
        n_cmp++; if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL ack_rx_rdy: got %b want 0", rx_rdy); end
        n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL ack_dout_hold: got %h want a5", dout); end
        tick();
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        wait_ticks(3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy: got %b want 1", busy); end
        wait_ticks(2);
        rxd = 1'b1;
        wait_ticks(10);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got busy=%b want 0", busy); end
        n_cmp++; if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL glitch_rx_rdy: got %b want 0", rx_rdy); end
        n_cmp++; if (dout !== exp_dout) begin n_bad++; $display("FAIL glitch_dout: got %h want %h", dout, exp_dout); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_ticks(12);
        n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL ferr_dout: got %h want 5a", dout); end
        n_cmp++; if (rx_rdy !== 1'b1) begin n_bad++; $display("FAIL ferr_rx_rdy: got %b want 1", rx_rdy); end
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
        pulse_rd();
        n_cmp++; if ({rx_rdy, frame_err} !== 2'b00) begin n_bad++; $display("FAIL ferr_clear: got rdy=%b fe=%b want 0 0", rx_rdy, frame_err); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        n_cmp++; if (dout !== 8'h22) begin n_bad++; $display("FAIL ovr_dout: got %h want 22", dout); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        send_frame(8'h33, 1'b1, 1'b1);
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_rd_clears: got %b want 0", overrun); end
        n_cmp++; if (rx_rdy !== 1'b1) begin n_bad++; $display("FAIL ovr_rd_rdy: got %b want 1", rx_rdy); end
        n_cmp++; if (dout !== 8'h33) begin n_bad++; $display("FAIL ovr_rd_dout: got %h want 33", dout); end
        pulse_rd();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        n_cmp++; if ({overrun, rx_rdy} !== 2'b01) begin n_bad++; $display("FAIL ovr_repeat: got ovr=%b rdy=%b want 0 1", overrun, rx_rdy); end
        n_cmp++; if (dout !== 8'h22) begin n_bad++; $display("FAIL ovr_repeat_dout: got %h want 22", dout); end
        pulse_rd();
    endtask

    task automatic test_loopback();
        logic [7:0] pats [4];
        pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h80; pats[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            send_frame(pats[i], 1'b1, 1'b0);
            n_cmp++; if (dout !== pats[i]) begin n_bad++; $display("FAIL loop_dout[%0d]: got %h want %h", i, dout, pats[i]); end
            n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL loop_frame_err[%0d]: got %b want 0", i, frame_err); end
            pulse_rd();
        end
    endtask

    task automatic test_random();
        logic [7:0] data;
        logic       stop;
        int         mode;
        for (int i = 0; i < 12; i++) begin
            data = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 2);
            wait_ticks($urandom_range(0, 3));
            send_frame(data, stop, mode == 1);
            if (!stop) wait_ticks(12);
            n_cmp++; if (dout !== exp_dout) begin n_bad++; $display("FAIL rand_dout[%0d]: got %h want %h", i, dout, exp_dout); end
            n_cmp++; if (rx_rdy !== exp_rdy) begin n_bad++; $display("FAIL rand_rx_rdy[%0d]: got %b want %b", i, rx_rdy, exp_rdy); end
            n_cmp++; if (frame_err !== exp_fe) begin n_bad++; $display("FAIL rand_frame_err[%0d]: got %b want %b", i, frame_err, exp_fe); end
            n_cmp++; if (overrun !== exp_ovr) begin n_bad++; $display("FAIL rand_overrun[%0d]: got %b want %b", i, overrun, exp_ovr); end
            if (mode == 2) begin
                pulse_rd();
                n_cmp++; if (rx_rdy !== exp_rdy) begin n_bad++; $display("FAIL rand_ack[%0d]: got %b want %b", i, rx_rdy, exp_rdy); end
            end
        end
        pulse_rd();
    endtask

    task automatic test_break();
        rxd = 1'b0;
        wait_ticks(DONE_TICK + 17);
        model_done(8'h00, 1'b0, 1'b0);
        n_cmp++; if (dout !== exp_dout) begin n_bad++; $display("FAIL break_dout: got %h want %h", dout, exp_dout); end
        n_cmp++; if (frame_err !== exp_fe) begin n_bad++; $display("FAIL break_frame_err: got %b want %b", frame_err, exp_fe); end
        n_cmp++; if (rx_rdy !== exp_rdy) begin n_bad++; $display("FAIL break_rx_rdy: got %b want %b", rx_rdy, exp_rdy); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL break_restart: got busy=%b want 1", busy); end
        rxd = 1'b1;
    endtask

    initial begin
        rst = 1'b0; rxd = 1'b1; rd = 1'b0;
        rdy_before = 1'b0; rdy_after = 1'b0;
        test_reset();
        test_nominal();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_loopback();
        test_random();
        test_break();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
